// File: rtl/muldiv_iter.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_iter
// Purpose  : Iterative signed/unsigned multiply (shift-add) and divide
//            (restoring) unit with stall request, annul and divide-by-zero.
// Revision : 1.0 - initial release
// ============================================================================
module muldiv_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             annul,
    output logic             stallreq,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result_hi,
    output logic [WIDTH-1:0] result_lo,
    output logic             div_by_zero
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic               w_accept;
    logic               w_neg_a;
    logic               w_neg_b;
    logic               w_div_zero;
    logic [WIDTH-1:0]   w_mag_a;
    logic [WIDTH-1:0]   w_mag_b;

    logic               r_is_div;
    logic               r_neg_a;
    logic               r_neg_res;
    logic               r_dz;
    logic               r_hold_dz;
    logic [CNT_W-1:0]   r_cnt;
    logic [2*WIDTH-1:0] r_acc;
    logic [2*WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0]   r_shift;
    logic [WIDTH-1:0]   r_dvsr;
    logic [WIDTH-1:0]   r_rem;
    logic [WIDTH-1:0]   r_out_hi;
    logic [WIDTH-1:0]   r_out_lo;
    logic [WIDTH-1:0]   r_hold_hi;
    logic [WIDTH-1:0]   r_hold_lo;

    logic [WIDTH:0]     w_rem_shift;
    logic [WIDTH:0]     w_rem_diff;
    logic [2*WIDTH-1:0] w_prod_fix;
    logic [WIDTH-1:0]   w_quo_fix;
    logic [WIDTH-1:0]   w_rem_fix;

    // Magnitude of MIN wraps to 2^(WIDTH-1), which is the correct unsigned value
    assign w_neg_a    = op[0] & src_a[WIDTH-1];
    assign w_neg_b    = op[0] & src_b[WIDTH-1];
    assign w_mag_a    = w_neg_a ? -src_a : src_a;
    assign w_mag_b    = w_neg_b ? -src_b : src_b;
    assign w_div_zero = op[1] & (src_b == '0);

    assign w_rem_shift = {r_rem, r_shift[WIDTH-1]};
    assign w_rem_diff  = w_rem_shift - {1'b0, r_dvsr};

    assign w_prod_fix = r_neg_res ? -r_acc : r_acc;
    assign w_quo_fix  = r_neg_res ? -r_shift : r_shift;
    assign w_rem_fix  = r_neg_a ? -r_rem : r_rem;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        stallreq    = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_accept = start & ~annul;
                stallreq = start & ~annul & ~rst;
                if (w_accept) begin
                    w_state_nxt = w_div_zero ? S_DONE : S_CALC;
                end
            end
            S_CALC: begin
                busy     = 1'b1;
                stallreq = 1'b1;
                if (annul) begin
                    w_state_nxt = S_IDLE;
                end else if (r_cnt == C_LAST) begin
                    w_state_nxt = S_FIX;
                end
            end
            S_FIX: begin
                busy        = 1'b1;
                stallreq    = 1'b1;
                w_state_nxt = annul ? S_IDLE : S_DONE;
            end
            S_DONE: begin
                busy        = 1'b1;
                done        = ~annul;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_is_div  <= 1'b0;
            r_neg_a   <= 1'b0;
            r_neg_res <= 1'b0;
            r_dz      <= 1'b0;
            r_hold_dz <= 1'b0;
            r_cnt     <= '0;
            r_acc     <= '0;
            r_mcand   <= '0;
            r_shift   <= '0;
            r_dvsr    <= '0;
            r_rem     <= '0;
            r_out_hi  <= '0;
            r_out_lo  <= '0;
            r_hold_hi <= '0;
            r_hold_lo <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_is_div  <= op[1];
                        r_neg_a   <= w_neg_a;
                        r_neg_res <= w_neg_a ^ w_neg_b;
                        r_dz      <= w_div_zero;
                        r_hold_dz <= 1'b0;
                        r_cnt     <= '0;
                        r_acc     <= '0;
                        r_rem     <= '0;
                        r_mcand   <= {{WIDTH{1'b0}}, w_mag_a};
                        r_shift   <= op[1] ? w_mag_a : w_mag_b;
                        r_dvsr    <= w_mag_b;
                        if (w_div_zero) begin
                            r_out_hi <= src_a;
                            r_out_lo <= '1;
                        end
                    end
                end
                S_CALC: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (r_is_div) begin
                        // Restoring step: keep the trial difference only if non-negative
                        r_rem   <= w_rem_diff[WIDTH] ? w_rem_shift[WIDTH-1:0]
                                                     : w_rem_diff[WIDTH-1:0];
                        r_shift <= {r_shift[WIDTH-2:0], ~w_rem_diff[WIDTH]};
                    end else begin
                        if (r_shift[0]) begin
                            r_acc <= r_acc + r_mcand;
                        end
                        r_mcand <= r_mcand << 1;
                        r_shift <= r_shift >> 1;
                    end
                end
                S_FIX: begin
                    if (r_is_div) begin
                        r_out_hi <= w_rem_fix;
                        r_out_lo <= w_quo_fix;
                    end else begin
                        r_out_hi <= w_prod_fix[2*WIDTH-1:WIDTH];
                        r_out_lo <= w_prod_fix[WIDTH-1:0];
                    end
                end
                S_DONE: begin
                    if (!annul) begin
                        r_hold_hi <= r_out_hi;
                        r_hold_lo <= r_out_lo;
                        r_hold_dz <= r_dz;
                    end
                end
                default: ;
            endcase
        end
    end

    // Fresh result is shown during the done pulse and committed as it ends
    assign result_hi   = done ? r_out_hi : r_hold_hi;
    assign result_lo   = done ? r_out_lo : r_hold_lo;
    assign div_by_zero = done ? r_dz     : r_hold_dz;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_iter.sv
`default_nettype none
// ============================================================================
// Module   : tb_muldiv_iter
// Purpose  : Directed self-checking bench for muldiv_iter at WIDTH 32 and 8.
// Revision : 1.0 - initial release
// ============================================================================
module tb_muldiv_iter;

    logic        clk = 1'b0;
    logic        rst;
    always #5 clk = ~clk;

    logic        start, annul, stallreq, busy, done, div_by_zero;
    logic [1:0]  op;
    logic [31:0] src_a, src_b, result_hi, result_lo;

    logic        start8, annul8, stall8, busy8, done8, dz8;
    logic [1:0]  op8;
    logic [7:0]  a8, b8, hi8, lo8;

    int checks = 0;
    int errors = 0;

    muldiv_iter #(.WIDTH(32)) u_dut32 (
        .clk(clk), .rst(rst), .start(start), .op(op), .src_a(src_a), .src_b(src_b),
        .annul(annul), .stallreq(stallreq), .busy(busy), .done(done),
        .result_hi(result_hi), .result_lo(result_lo), .div_by_zero(div_by_zero)
    );

    muldiv_iter #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst), .start(start8), .op(op8), .src_a(a8), .src_b(b8),
        .annul(annul8), .stallreq(stall8), .busy(busy8), .done(done8),
        .result_hi(hi8), .result_lo(lo8), .div_by_zero(dz8)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic run32(input string tag, input logic [1:0] o, input logic [31:0] a,
                         input logic [31:0] b, input int lat, input logic [31:0] ehi,
                         input logic [31:0] elo, input logic edz);
        int   n;
        logic stall_ok;
        @(negedge clk);
        op = o; src_a = a; src_b = b; start = 1'b1;
        #1;
        check({tag, "_stall_T"}, 64'(stallreq), 64'd1);
        @(negedge clk);
        start = 1'b0;
        n = 1;
        stall_ok = 1'b1;
        if (lat > 1) check({tag, "_dz_clr"}, 64'(div_by_zero), 64'd0);
        while (!done && n < 200) begin
            stall_ok = stall_ok & stallreq;
            @(negedge clk);
            n++;
        end
        check({tag, "_lat"}, 64'(n), 64'(lat));
        check({tag, "_stall_run"}, 64'(stall_ok), 64'd1);
        check({tag, "_stall_done"}, 64'(stallreq), 64'd0);
        check({tag, "_hi"}, 64'(result_hi), 64'(ehi));
        check({tag, "_lo"}, 64'(result_lo), 64'(elo));
        check({tag, "_dz"}, 64'(div_by_zero), 64'(edz));
        @(negedge clk);
        check({tag, "_pulse"}, 64'(done), 64'd0);
        check({tag, "_hold_lo"}, 64'(result_lo), 64'(elo));
        check({tag, "_hold_dz"}, 64'(div_by_zero), 64'(edz));
    endtask

    task automatic run8(input string tag, input logic [1:0] o, input logic [7:0] a,
                        input logic [7:0] b, input int lat, input logic [7:0] ehi,
                        input logic [7:0] elo, input logic edz);
        int n;
        @(negedge clk);
        op8 = o; a8 = a; b8 = b; start8 = 1'b1;
        #1;
        check({tag, "_stall_T"}, 64'(stall8), 64'd1);
        @(negedge clk);
        start8 = 1'b0;
        n = 1;
        while (!done8 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_lat"}, 64'(n), 64'(lat));
        check({tag, "_hi"}, 64'(hi8), 64'(ehi));
        check({tag, "_lo"}, 64'(lo8), 64'(elo));
        check({tag, "_dz"}, 64'(dz8), 64'(edz));
        @(negedge clk);
        check({tag, "_pulse"}, 64'(done8), 64'd0);
    endtask

    initial begin
        logic seen;
        rst = 1'b1;
        start = 1'b0; annul = 1'b0; op = 2'b00; src_a = '0; src_b = '0;
        start8 = 1'b0; annul8 = 1'b0; op8 = 2'b00; a8 = '0; b8 = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_done", 64'(done), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_stall", 64'(stallreq), 64'd0);
        check("rst_hi", 64'(result_hi), 64'd0);
        check("rst_lo", 64'(result_lo), 64'd0);
        check("rst_dz", 64'(div_by_zero), 64'd0);
        check("rst_busy8", 64'(busy8), 64'd0);

        // WIDTH=8 vectors
        run8("u8_div200_7", 2'b10, 8'hC8, 8'h07, 10, 8'h04, 8'h1C, 1'b0);
        run8("s8_mul_min_min", 2'b01, 8'h80, 8'h80, 10, 8'h40, 8'h00, 1'b0);
        run8("s8_div_min_m1", 2'b11, 8'h80, 8'hFF, 10, 8'h00, 8'h80, 1'b0);
        run8("u8_mul_ff_ff", 2'b00, 8'hFF, 8'hFF, 10, 8'hFE, 8'h01, 1'b0);
        run8("s8_div_zero", 2'b11, 8'h5A, 8'h00, 1, 8'h5A, 8'hFF, 1'b1);

        // WIDTH=32 vectors
        run32("u_mul_ffff_2", 2'b00, 32'hFFFFFFFF, 32'h00000002, 34, 32'h00000001, 32'hFFFFFFFE, 1'b0);
        run32("s_div_m7_2", 2'b11, 32'hFFFFFFF9, 32'h00000002, 34, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
        run32("s_mul_m3_5", 2'b01, 32'hFFFFFFFD, 32'h00000005, 34, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0);
        run32("u_div_zero", 2'b10, 32'h12345678, 32'h00000000, 1, 32'h12345678, 32'hFFFFFFFF, 1'b1);
        run32("s_div_zero", 2'b11, 32'h12345678, 32'h00000000, 1, 32'h12345678, 32'hFFFFFFFF, 1'b1);
        run32("u_mul_3_4", 2'b00, 32'h00000003, 32'h00000004, 34, 32'h00000000, 32'h0000000C, 1'b0);
        run32("s_div_min_m1", 2'b11, 32'h80000000, 32'hFFFFFFFF, 34, 32'h00000000, 32'h80000000, 1'b0);
        run32("u_div_100_7", 2'b10, 32'd100, 32'd7, 34, 32'd2, 32'd14, 1'b0);

        // Annul a divide in cycle T+10
        @(negedge clk);
        op = 2'b10; src_a = 32'd1000; src_b = 32'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        check("annul_busy_before", 64'(busy), 64'd1);
        annul = 1'b1;
        @(negedge clk);
        annul = 1'b0;
        check("annul_idle", 64'(busy), 64'd0);
        check("annul_stall", 64'(stallreq), 64'd0);
        seen = 1'b0;
        repeat (40) begin
            seen = seen | done;
            @(negedge clk);
        end
        check("annul_no_done", 64'(seen), 64'd0);
        check("annul_keep_hi", 64'(result_hi), 64'd2);
        check("annul_keep_lo", 64'(result_lo), 64'd14);

        // Reset in cycle T+5 of a multiply, then a normal operation
        @(negedge clk);
        op = 2'b00; src_a = 32'd7; src_b = 32'd6; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_done", 64'(done), 64'd0);
        check("midrst_stall", 64'(stallreq), 64'd0);
        check("midrst_hi", 64'(result_hi), 64'd0);
        check("midrst_lo", 64'(result_lo), 64'd0);
        run32("after_rst_mul", 2'b00, 32'd9, 32'd11, 34, 32'd0, 32'd99, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/muldiv_iter.md
# muldiv_iter

Parametrised multi-cycle integer multiply/divide unit for the EX stage. It accepts one operation per start request and computes signed or unsigned multiply by shift-add, or divide by restoring division, over WIDTH iterations. It raises a stall request to the pipeline controller while busy and returns a 2×WIDTH result split into hi/lo halves for HI/LO writeback. It supersedes the fixed 32-bit divider and combinational multiplier: one datapath, configurable width, annul support, and defined divide-by-zero behaviour.

## Interface
- WIDTH, 32, operand width in bits; legal values are 4..64, even.
- clk  in  1  clock.
- rst  in  1  reset: synchronous, active-high.
- start  in  1  request an operation; sampled only in IDLE.
- op  in  2  operation select: op[1]=1 divide, op[1]=0 multiply; op[0]=1 signed, op[0]=0 unsigned.
- src_a  in  WIDTH  multiplicand or dividend.
- src_b  in  WIDTH  multiplier or divisor.
- annul  in  1  abort the in-flight operation (flush).
- stallreq  out  1  pipeline stall request.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse; result_hi and result_lo are valid in this cycle.
- result_hi  out  WIDTH  multiply: upper product half. Divide: remainder.
- result_lo  out  WIDTH  multiply: lower product half. Divide: quotient.
- div_by_zero  out  1  high together with done when a divide had src_b==0.

## Operation
- States: IDLE, CALC, FIX, DONE.
- IDLE:
  - start=1 and annul=0 → latch op and operand magnitudes, clear the iteration counter, go to CALC.
  - If the operation is a divide and src_b==0, go to DONE instead, with result_hi=src_a, result_lo=all-ones, div_by_zero=1.
- Signed mode uses magnitudes for both operands. Taking the magnitude of MIN wraps to an unsigned value equal to 2^(WIDTH-1), which is correct.
- CALC: one iteration per cycle for exactly WIDTH cycles, then go to FIX.
  - Multiply: 2W-bit accumulator; add the shifted multiplicand when the current multiplier bit is 1.
  - Divide: (W+1)-bit partial remainder; shift in the next dividend bit, trial-subtract the divisor, and set the quotient bit when the result is non-negative.
- FIX: sign correction.
  - Multiply, signed, operand signs differ: negate the full 2W-bit product.
  - Divide, signed: negate the quotient if the operand signs differ; the remainder takes the sign of the dividend.
  - Unsigned operations pass through unchanged.
  - Then go to DONE.
- DONE: register the results, done=1 for this cycle only, next state IDLE. start is ignored in DONE.
- result_hi, result_lo and div_by_zero hold their values until the next DONE or reset. div_by_zero clears on the next accepted start.
- Signed MIN/−1: quotient=MIN, remainder=0 (wraps). This is not flagged.
- stallreq = (IDLE & start & ~annul) | CALC | FIX. stallreq is low in DONE, so the pipeline advances in the DONE cycle and captures the result.
- annul in CALC, FIX or DONE → IDLE on the next edge. done is then not asserted and the result registers are unchanged. annul in IDLE blocks acceptance.
- rst, at any time including mid-operation: state=IDLE; all outputs are 0 and all internal registers are cleared.

## Timing
- start is accepted at the edge ending cycle T.
- Normal operation: CALC in T+1..T+WIDTH, FIX in T+WIDTH+1, DONE (done=1) in T+WIDTH+2. For WIDTH=32, done is at T+34.
- Divide by zero: DONE in T+1.
- stallreq is high from T (combinational on start) through the cycle before DONE.
- Back-to-back operations: a new start is accepted at the earliest in the IDLE cycle after DONE, giving a minimum issue interval of WIDTH+3 cycles.
- done, busy and stallreq are all 0 in the cycle after rst.

## Test plan
- Unsigned multiply, WIDTH=32, 0xFFFFFFFF×0x00000002 → done at T+34; result_hi=0x00000001, result_lo=0xFFFFFFFE; stallreq high T..T+33.
- Signed divide −7/2 (0xFFFFFFF9, 0x00000002) → result_lo=0xFFFFFFFD, result_hi=0xFFFFFFFF. Signed multiply −3×5 → result_hi=0xFFFFFFFF, result_lo=0xFFFFFFF1.
- Divide 0x12345678/0 (either mode) → done at T+1, div_by_zero=1, result_hi=0x12345678, result_lo=0xFFFFFFFF; the next multiply clears div_by_zero.
- Signed 0x80000000/0xFFFFFFFF → result_lo=0x80000000, result_hi=0, div_by_zero=0.
- Annul at T+10 of a divide → IDLE at T+11; no done pulse; results keep their previous values. Separately, rst at T+5 → all outputs 0; a start two cycles later completes normally.
- WIDTH=8: unsigned 200/7 → result_lo=28, result_hi=4, done at T+10; signed 0x80×0x80 → result_hi=0x40, result_lo=0x00.
